// File: rtl/arith_share_pkg.sv
// -----------------------------------------------------------------------------
// arith_share_pkg
// Purpose : Shared definitions for the arithmetic-sharing scheduler: op-code
//           encodings and the scheduler state type.
// Contents: OP_ADD..OP_MOD op codes (5..7 are illegal), state_t {IDLE, EXEC,
//           RESP}.
// -----------------------------------------------------------------------------
package arith_share_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_MOD = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Purpose : Unsigned restoring divider, one quotient bit per clock.
//           The first iteration is performed on the start edge itself, so
//           `done` is high in the WIDTH-th cycle after the start cycle and
//           quotient/remainder are valid while `done` is high.
// Ports   : clk, reset (async, active-low)
//           start          - load a/b and begin (ignored divisor==0 handling
//                            is the caller's job)
//           a, b           - dividend, divisor
//           done           - one-cycle pulse when the result is ready
//           quotient,
//           remainder      - result
// -----------------------------------------------------------------------------
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvs;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_src_rem;
    logic [WIDTH-1:0] w_src_quot;
    logic [WIDTH-1:0] w_src_dvs;
    logic [WIDTH:0]   w_shifted;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_nxt_rem;
    logic [WIDTH-1:0] w_nxt_quot;

    // On start the step works on the fresh operands, otherwise on the
    // registered partial result.
    assign w_src_rem  = start ? '0 : r_rem;
    assign w_src_quot = start ? a  : r_quot;
    assign w_src_dvs  = start ? b  : r_dvs;

    // Shift the next dividend bit into the partial remainder and try to
    // subtract; a borrow (MSB set) means restore.
    assign w_shifted  = {w_src_rem, w_src_quot[WIDTH-1]};
    assign w_diff     = w_shifted - {1'b0, w_src_dvs};
    assign w_nxt_rem  = w_diff[WIDTH] ? w_shifted[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign w_nxt_quot = {w_src_quot[WIDTH-2:0], ~w_diff[WIDTH]};

    // NOTE: the iteration registers are reset so a divide aborted by reset
    // leaves no stale partial result behind.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_quot <= '0;
            r_rem  <= '0;
            r_dvs  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_quot <= w_nxt_quot;
                r_rem  <= w_nxt_rem;
                r_dvs  <= b;
                r_cnt  <= CW'(1);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_quot <= w_nxt_quot;
                r_rem  <= w_nxt_rem;
                r_cnt  <= r_cnt + 1'b1;
                if (r_cnt == CW'(WIDTH - 1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign done      = r_done;
    assign quotient  = r_quot;
    assign remainder = r_rem;

endmodule

// File: rtl/arith_share_sched.sv
// -----------------------------------------------------------------------------
// arith_share_sched
// Purpose : Round-robin scheduler sharing one add/sub/mul/div/mod datapath
//           between NREQ requesters; each result is returned tagged with the
//           id of the requester that issued it.
// Ports   : clk, reset (async, active-low)
//           req_valid[NREQ]        - per-requester request
//           req_ready[NREQ]        - one-hot grant (IDLE only), else zero
//           req_op[3*NREQ]         - op code, requester i at [3i+2:3i]
//           req_a/req_b[WIDTH*NREQ]- operands, requester i at slice i
//           rsp_valid/rsp_ready    - registered result handshake
//           rsp_id                 - owner of the result
//           rsp_data[2*WIDTH]      - zero-extended result
//           rsp_err                - divide-by-zero or illegal op
// -----------------------------------------------------------------------------
module arith_share_sched
    import arith_share_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [3*NREQ-1:0]        req_op,
    input  logic [WIDTH*NREQ-1:0]    req_a,
    input  logic [WIDTH*NREQ-1:0]    req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [2*WIDTH-1:0]       rsp_data,
    output logic                     rsp_err
);

    localparam int IDW = $clog2(NREQ);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDW-1:0]     r_ptr;
    logic [IDW-1:0]     r_id;
    logic               r_is_mod;
    logic               r_rsp_valid;
    logic [IDW-1:0]     r_rsp_id;
    logic [2*WIDTH-1:0] r_rsp_data;
    logic               r_rsp_err;

    logic               w_any;
    logic [IDW-1:0]     w_grant;
    logic               w_accept;
    logic               w_start;
    logic [2:0]         w_sel_op;
    logic [WIDTH-1:0]   w_sel_a;
    logic [WIDTH-1:0]   w_sel_b;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_diff;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_res_data;
    logic               w_res_err;
    logic               w_res_slow;
    logic               w_div_done;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;

    // Round-robin search: first valid requester at or above r_ptr, wrapping.
    always_comb begin
        int idx;
        w_any   = 1'b0;
        w_grant = '0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!w_any && req_valid[idx]) begin
                w_any   = 1'b1;
                w_grant = IDW'(idx);
            end
        end
    end

    assign w_sel_op = req_op[3*int'(w_grant) +: 3];
    assign w_sel_a  = req_a[WIDTH*int'(w_grant) +: WIDTH];
    assign w_sel_b  = req_b[WIDTH*int'(w_grant) +: WIDTH];

    assign w_sum  = {1'b0, w_sel_a} + {1'b0, w_sel_b};
    assign w_diff = w_sel_a - w_sel_b;
    assign w_prod = {{WIDTH{1'b0}}, w_sel_a} * {{WIDTH{1'b0}}, w_sel_b};

    // Result of the granted request; w_res_slow marks a real divide that
    // must go through the iterative divider instead.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the case leaves it unassigned (which infers a latch).
        w_res_data = '0;
        w_res_err  = 1'b0;
        w_res_slow = 1'b0;
        case (w_sel_op)
            OP_ADD: w_res_data = {{(WIDTH-1){1'b0}}, w_sum};
            OP_SUB: w_res_data = {{WIDTH{1'b0}}, w_diff};
            OP_MUL: w_res_data = w_prod;
            OP_DIV: begin
                if (w_sel_b == '0) begin
                    w_res_data = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
                    w_res_err  = 1'b1;
                end else begin
                    w_res_slow = 1'b1;
                end
            end
            OP_MOD: begin
                if (w_sel_b == '0) begin
                    w_res_data = {{WIDTH{1'b0}}, w_sel_a};
                    w_res_err  = 1'b1;
                end else begin
                    w_res_slow = 1'b1;
                end
            end
            default: w_res_err = 1'b1;
        endcase
    end

    // Next state and grant. req_ready is also masked by reset so it reads
    // zero while reset is held.
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        w_accept    = 1'b0;
        w_start     = 1'b0;
        case (r_state)
            IDLE: begin
                if (reset && w_any) begin
                    req_ready[w_grant] = 1'b1;
                    w_accept           = 1'b1;
                    w_start            = w_res_slow;
                    w_state_nxt        = w_res_slow ? EXEC : RESP;
                end
            end
            EXEC: if (w_div_done) w_state_nxt = RESP;
            RESP: if (r_rsp_valid && rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr       <= '0;
            r_id        <= '0;
            r_is_mod    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_ptr    <= (w_grant == IDW'(NREQ - 1)) ? '0 : w_grant + 1'b1;
                r_id     <= w_grant;
                r_is_mod <= (w_sel_op == OP_MOD);
                if (!w_res_slow) begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_id    <= w_grant;
                    r_rsp_data  <= w_res_data;
                    r_rsp_err   <= w_res_err;
                end
            end
            if (r_state == EXEC && w_div_done) begin
                r_rsp_valid <= 1'b1;
                r_rsp_id    <= r_id;
                r_rsp_data  <= {{WIDTH{1'b0}}, (r_is_mod ? w_rem : w_quot)};
                r_rsp_err   <= 1'b0;
            end
            if (r_state == RESP && r_rsp_valid && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    seq_divider #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (w_start),
        .a         (w_sel_a),
        .b         (w_sel_b),
        .done      (w_div_done),
        .quotient  (w_quot),
        .remainder (w_rem)
    );

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_arith_share_sched.sv
// -----------------------------------------------------------------------------
// tb_arith_share_sched
// Purpose : Self-checking bench for arith_share_sched (NREQ=4, WIDTH=8).
//           Expected results come from a plain-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_arith_share_sched;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [11:0] req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_data;
    logic        rsp_err;

    int n_cmp = 0;
    int n_bad = 0;

    arith_share_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the result rules written as ordinary arithmetic.
    function automatic void ref_model(input int op, input int a, input int b,
                                      output logic [15:0] d, output logic e);
        d = '0;
        e = 1'b0;
        case (op)
            0: d = 16'(a + b);
            1: d = 16'((a - b + 256) % 256);
            2: d = 16'(a * b);
            3: if (b == 0) begin d = 16'd255; e = 1'b1; end else d = 16'(a / b);
            4: if (b == 0) begin d = 16'(a);  e = 1'b1; end else d = 16'(a % b);
            default: e = 1'b1;
        endcase
    endfunction

    task automatic set_req(input int id, input int op, input int a, input int b);
        logic [2:0] op3;
        logic [7:0] a8;
        logic [7:0] b8;
        op3 = 3'(op);
        a8  = 8'(a);
        b8  = 8'(b);
        req_op[id*3 +: 3] = op3;
        req_a[id*8 +: 8]  = a8;
        req_b[id*8 +: 8]  = b8;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        reset     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        reset = 1'b1;
    endtask

    // Wait (bounded) for rsp_valid; returns positioned at that negedge.
    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (rsp_valid) begin ok = 1'b1; break; end
        end
    endtask

    // One complete transaction from a single requester with rsp_ready=1.
    // lat counts cycles from the acceptance cycle to the first rsp_valid cycle.
    task automatic do_op(input int id, input int op, input int a, input int b,
                         output logic [15:0] d, output logic e, output int rid,
                         output int lat, output bit ok);
        bit got;
        ok  = 1'b1;
        d   = '0;
        e   = 1'b0;
        rid = -1;
        lat = 0;
        @(posedge clk); #1;
        set_req(id, op, a, b);
        req_valid[id] = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (req_ready[id]) begin got = 1'b1; break; end
        end
        if (!got) begin ok = 1'b0; req_valid[id] = 1'b0; return; end
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        set_req(id, int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 255)));
        got = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (rsp_valid) begin got = 1'b1; lat = c; break; end
        end
        if (!got) begin ok = 1'b0; return; end
        d   = rsp_data;
        e   = rsp_err;
        rid = int'(rsp_id);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b0 || rsp_data !== 16'd0 || rsp_id !== 2'd0 ||
            rsp_err !== 1'b0 || req_ready !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_values: valid=%b data=%0d id=%0d err=%b ready=%b, want 0/0/0/0/0000",
                     rsp_valid, rsp_data, rsp_id, rsp_err, req_ready);
        end
        req_valid = '0;
        #1 reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
            n_bad++;
            $display("FAIL idle_no_request: valid=%b ready=%b, want 0 and 0000", rsp_valid, req_ready);
        end
    endtask

    task automatic test_add();
        logic [15:0] d; logic e; int rid; int lat; bit ok;
        do_op(2, 0, 200, 100, d, e, rid, lat, ok);
        n_cmp++;
        if (!ok || d !== 16'd300 || e !== 1'b0 || rid != 2 || lat != 1) begin
            n_bad++;
            $display("FAIL add_200_100: ok=%0d data=%0d err=%b id=%0d lat=%0d, want 300/0/2/1",
                     ok, d, e, rid, lat);
        end
    endtask

    task automatic test_mul_sub();
        logic [15:0] d; logic e; int rid; int lat; bit ok;
        do_op(0, 2, 255, 255, d, e, rid, lat, ok);
        n_cmp++;
        if (!ok || d !== 16'd65025 || e !== 1'b0 || rid != 0 || lat != 1) begin
            n_bad++;
            $display("FAIL mul_255_255: ok=%0d data=%0d err=%b id=%0d lat=%0d, want 65025/0/0/1",
                     ok, d, e, rid, lat);
        end
        do_op(0, 1, 3, 5, d, e, rid, lat, ok);
        n_cmp++;
        if (!ok || d !== 16'd254 || e !== 1'b0 || rid != 0 || lat != 1) begin
            n_bad++;
            $display("FAIL sub_3_5: ok=%0d data=%0d err=%b id=%0d lat=%0d, want 254/0/0/1",
                     ok, d, e, rid, lat);
        end
    endtask

    task automatic test_div_mod();
        logic [15:0] d; logic e; int rid; int lat; bit ok;
        do_op(1, 3, 200, 7, d, e, rid, lat, ok);
        n_cmp++;
        if (!ok || d !== 16'd28 || e !== 1'b0 || rid != 1 || lat != 9) begin
            n_bad++;
            $display("FAIL div_200_7: ok=%0d data=%0d err=%b id=%0d lat=%0d, want 28/0/1/9",
                     ok, d, e, rid, lat);
        end
        do_op(1, 4, 200, 7, d, e, rid, lat, ok);
        n_cmp++;
        if (!ok || d !== 16'd4 || e !== 1'b0 || rid != 1 || lat != 9) begin
            n_bad++;
            $display("FAIL mod_200_7: ok=%0d data=%0d err=%b id=%0d lat=%0d, want 4/0/1/9",
                     ok, d, e, rid, lat);
        end
    endtask

    task automatic test_div_zero_illegal();
        logic [15:0] d; logic e; int rid; int lat; bit ok;
        do_op(3, 3, 9, 0, d, e, rid, lat, ok);
        n_cmp++;
        if (!ok || d !== 16'd255 || e !== 1'b1 || rid != 3 || lat != 1) begin
            n_bad++;
            $display("FAIL div_by_zero: ok=%0d data=%0d err=%b id=%0d lat=%0d, want 255/1/3/1",
                     ok, d, e, rid, lat);
        end
        do_op(3, 4, 9, 0, d, e, rid, lat, ok);
        n_cmp++;
        if (!ok || d !== 16'd9 || e !== 1'b1 || rid != 3 || lat != 1) begin
            n_bad++;
            $display("FAIL mod_by_zero: ok=%0d data=%0d err=%b id=%0d lat=%0d, want 9/1/3/1",
                     ok, d, e, rid, lat);
        end
        do_op(3, 6, 17, 4, d, e, rid, lat, ok);
        n_cmp++;
        if (!ok || d !== 16'd0 || e !== 1'b1 || rid != 3 || lat != 1) begin
            n_bad++;
            $display("FAIL illegal_op6: ok=%0d data=%0d err=%b id=%0d lat=%0d, want 0/1/3/1",
                     ok, d, e, rid, lat);
        end
    endtask

    // All four requesters hold valid; requester 1 divides so EXEC is visited.
    task automatic test_round_robin();
        int ops[4];
        int as[4];
        int bs[4];
        int grants[5];
        int ng;
        int nrsp;
        int viol;
        bit pending;
        logic [15:0] ed;
        logic ee;
        ops = '{0, 3, 2, 1};
        as  = '{10, 200, 12, 7};
        bs  = '{20, 7, 11, 9};
        do_reset();
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) set_req(i, ops[i], as[i], bs[i]);
        req_valid = 4'hF;
        ng = 0; nrsp = 0; viol = 0; pending = 1'b0;
        for (int c = 0; c < 150 && !(ng >= 5 && !pending); c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                if (|req_ready) viol++;
                ref_model(ops[rsp_id], as[rsp_id], bs[rsp_id], ed, ee);
                n_cmp++;
                if (rsp_data !== ed || rsp_err !== ee) begin
                    n_bad++;
                    $display("FAIL rr_result id=%0d: data=%0d err=%b, want %0d/%b",
                             rsp_id, rsp_data, rsp_err, ed, ee);
                end
                nrsp++;
                pending = 1'b0;
            end else if (|req_ready) begin
                if (pending || !$onehot(req_ready)) viol++;
                for (int i = 0; i < 4; i++) if (req_ready[i] && ng < 5) grants[ng] = i;
                ng++;
                pending = 1'b1;
                if (ng == 5) begin
                    @(posedge clk); #1;
                    req_valid = '0;
                end
            end
        end
        req_valid = '0;
        n_cmp++;
        if (ng != 5 || nrsp != 5) begin
            n_bad++;
            $display("FAIL rr_count: grants=%0d responses=%0d, want 5/5", ng, nrsp);
        end else begin
            n_cmp++;
            if (grants[0] != 0 || grants[1] != 1 || grants[2] != 2 ||
                grants[3] != 3 || grants[4] != 0) begin
                n_bad++;
                $display("FAIL rr_order: got %0d,%0d,%0d,%0d,%0d want 0,1,2,3,0",
                         grants[0], grants[1], grants[2], grants[3], grants[4]);
            end
        end
        n_cmp++;
        if (viol != 0) begin
            n_bad++;
            $display("FAIL rr_ready_busy: %0d cycles with req_ready while busy, want 0", viol);
        end
        @(posedge clk); #1;
    endtask

    // Held-off response must stay stable; the next grant wraps 3 -> 0.
    task automatic test_backpressure();
        bit ok;
        int bad_cycles;
        do_reset();
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        set_req(3, 0, 50, 60);
        set_req(0, 1, 10, 3);
        set_req(2, 2, 2, 3);
        req_valid = 4'b1000;
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (req_ready[3]) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        req_valid = 4'b0101;
        set_req(3, 2, 99, 99);
        if (ok) wait_rsp(ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL bp_first_rsp: no response within bound, want one");
        end
        bad_cycles = 0;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_data !== 16'd110 || rsp_id !== 2'd3 ||
                rsp_err !== 1'b0 || req_ready !== 4'b0000) bad_cycles++;
        end
        n_cmp++;
        if (bad_cycles != 0) begin
            n_bad++;
            $display("FAIL bp_stable: %0d of 6 cycles deviated from 110/id3/err0/ready0", bad_cycles);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_bad++;
            $display("FAIL bp_wrap_grant: req_ready=%b, want 0001", req_ready);
        end
        @(posedge clk); #1;
        req_valid = '0;
        wait_rsp(ok);
        n_cmp++;
        if (!ok || rsp_data !== 16'd7 || rsp_id !== 2'd0 || rsp_err !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_second_rsp: ok=%0d data=%0d id=%0d err=%b, want 7/0/0",
                     ok, rsp_data, rsp_id, rsp_err);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_exec();
        bit ok;
        int seen;
        do_reset();
        @(posedge clk); #1;
        set_req(2, 3, 200, 7);
        set_req(0, 0, 1, 2);
        set_req(3, 0, 5, 5);
        req_valid = 4'b0100;
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (req_ready[2]) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        req_valid = '0;
        repeat (3) @(posedge clk);
        #2;
        reset     = 1'b0;
        req_valid = 4'b1001;
        @(negedge clk);
        n_cmp++;
        if (!ok || rsp_valid !== 1'b0 || req_ready !== 4'b0000 || rsp_data !== 16'd0) begin
            n_bad++;
            $display("FAIL rst_exec_outputs: ok=%0d valid=%b ready=%b data=%0d, want 1/0/0000/0",
                     ok, rsp_valid, req_ready, rsp_data);
        end
        req_valid = '0;
        #1 reset = 1'b1;
        seen = 0;
        repeat (14) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL rst_exec_no_rsp: rsp_valid high %0d cycles, want 0", seen);
        end
        @(posedge clk); #1;
        req_valid = 4'b1001;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_bad++;
            $display("FAIL rst_exec_next_grant: req_ready=%b, want 0001", req_ready);
        end
        @(posedge clk); #1;
        req_valid = '0;
        wait_rsp(ok);
        n_cmp++;
        if (!ok || rsp_data !== 16'd3 || rsp_id !== 2'd0) begin
            n_bad++;
            $display("FAIL rst_exec_after_rsp: ok=%0d data=%0d id=%0d, want 3/0", ok, rsp_data, rsp_id);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [15:0] d; logic e; int rid; int lat; bit ok;
        logic [15:0] ed; logic ee;
        int id; int op; int a; int b; int elat;
        for (int n = 0; n < 40; n++) begin
            id = int'($urandom_range(0, 3));
            op = ($urandom_range(0, 4) == 0) ? int'($urandom_range(5, 7))
                                             : int'($urandom_range(0, 4));
            a  = int'($urandom_range(0, 255));
            b  = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(0, 255));
            ref_model(op, a, b, ed, ee);
            elat = ((op == 3 || op == 4) && b != 0) ? 9 : 1;
            do_op(id, op, a, b, d, e, rid, lat, ok);
            n_cmp++;
            if (!ok || d !== ed || e !== ee || rid != id || lat != elat) begin
                n_bad++;
                $display("FAIL random_%0d op=%0d a=%0d b=%0d: ok=%0d data=%0d err=%b id=%0d lat=%0d, want %0d/%b/%0d/%0d",
                         n, op, a, b, ok, d, e, rid, lat, ed, ee, id, elat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul_sub();
        test_div_mod();
        test_div_zero_illegal();
        test_round_robin();
        test_backpressure();
        test_reset_mid_exec();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
